// File: rtl/lfsr_stream_if.sv
// Stream bundle for the LFSR source: control and seed in, presented word and status out.
interface lfsr_stream_if #(
    parameter int WIDTH = 8
);
    logic             load_i;
    logic [WIDTH-1:0] seed_i;
    logic             ready_i;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic             wrap_o;
    logic [WIDTH-1:0] period_o;
    logic             zseed_o;

    modport master (
        input  load_i, seed_i, ready_i,
        output valid_o, data_o, wrap_o, period_o, zseed_o
    );

    modport slave (
        output load_i, seed_i, ready_i,
        input  valid_o, data_o, wrap_o, period_o, zseed_o
    );
endinterface

// File: rtl/lfsr_stream.sv
// Galois LFSR pseudo-random stream source with seed load, warm-up discard,
// multi-step advance and period/wrap detection.
module lfsr_stream #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'h1D,
    parameter logic [WIDTH-1:0] SEED   = 8'hFF,
    parameter int               STEP   = 1,
    parameter int               WARMUP = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    lfsr_stream_if.master bus
);
    typedef enum logic {WARM = 1'b0, RUN = 1'b1} fsm_e;

    localparam fsm_e       INIT_FSM  = (WARMUP == 0) ? RUN : WARM;
    localparam logic [7:0] WARM_INIT = 8'(WARMUP);

    fsm_e             fsm_q, fsm_d;
    logic [7:0]       warm_q, warm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q, wrap_d;
    logic             zseed_q, zseed_d;
    logic [WIDTH-1:0] adv;
    logic             zero_seed;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] q);
        return {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? TAPS : '0);
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] r;
        r = q;
        for (int i = 0; i < STEP; i++) r = lfsr_step(r);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        adv       = lfsr_advance(state_q);
        zero_seed = (bus.seed_i == '0);
        fsm_d     = fsm_q;
        warm_d    = warm_q;
        state_d   = state_q;
        ref_d     = ref_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        wrap_d    = 1'b0;
        zseed_d   = 1'b0;
        // A load wins over any same-cycle handshake; period_o survives it.
        if (bus.load_i) begin
            zseed_d = zero_seed;
            state_d = zero_seed ? SEED : bus.seed_i;
            fsm_d   = INIT_FSM;
            warm_d  = WARM_INIT;
            cnt_d   = '0;
            if (WARMUP == 0) ref_d = state_d;
        end else if (fsm_q == WARM) begin
            state_d = adv;
            warm_d  = warm_q - 8'd1;
            if (warm_q <= 8'd1) begin
                fsm_d = RUN;
                ref_d = adv;
                cnt_d = '0;
            end
        end else if (bus.ready_i) begin
            state_d = adv;
            cnt_d   = sat_inc(cnt_q);
            if (adv == ref_q) begin
                wrap_d   = 1'b1;
                period_d = sat_inc(cnt_q);
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q    <= INIT_FSM;
            warm_q   <= WARM_INIT;
            state_q  <= SEED;
            ref_q    <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            zseed_q  <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            warm_q   <= warm_d;
            state_q  <= state_d;
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
            zseed_q  <= zseed_d;
        end
    end

    assign bus.valid_o  = (fsm_q == RUN);
    assign bus.data_o   = state_q;
    assign bus.wrap_o   = wrap_q;
    assign bus.period_o = period_q;
    assign bus.zseed_o  = zseed_q;
endmodule

// File: tb/tb_lfsr_stream.sv
// Directed and randomised checks of lfsr_stream against a GF(2) multiply-by-x model.
module tb_lfsr_stream;
    logic clk;
    logic rst8_n, rst4_n, rstw_n;
    int   errors, checks;

    lfsr_stream_if #(.WIDTH(8)) b8 ();
    lfsr_stream_if #(.WIDTH(4)) b4 ();
    lfsr_stream_if #(.WIDTH(8)) bw ();

    lfsr_stream #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'hFF), .STEP(1), .WARMUP(0))
        u_d8 (.clk_i(clk), .rst_ni(rst8_n), .bus(b8));
    lfsr_stream #(.WIDTH(4), .TAPS(4'h7), .SEED(4'hF), .STEP(1), .WARMUP(0))
        u_d4 (.clk_i(clk), .rst_ni(rst4_n), .bus(b4));
    lfsr_stream #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'hFF), .STEP(1), .WARMUP(3))
        u_dw (.clk_i(clk), .rst_ni(rstw_n), .bus(bw));

    always #5 clk = ~clk;

    // Multiply by x modulo the feedback polynomial x^w + taps.
    function automatic int unsigned mulx(int unsigned q, int w, int unsigned taps);
        int unsigned t;
        t = q * 2;
        if (t >= (32'd1 << w)) t = (t - (32'd1 << w)) ^ taps;
        return t;
    endfunction

    function automatic int unsigned nth(int unsigned start, int n, int w, int unsigned taps);
        int unsigned q;
        q = start;
        for (int i = 0; i < n; i++) q = mulx(q, w, taps);
        return q;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp1 [4];
        logic [31:0] exp4 [8];
        int unsigned q, s, n;
        logic r, expw;

        exp1 = '{32'hFF, 32'hE3, 32'hDB, 32'hAB};
        exp4 = '{32'hF, 32'h9, 32'h5, 32'hA, 32'h3, 32'h6, 32'hC, 32'hF};
        errors = 0; checks = 0; clk = 0;
        rst8_n = 0; rst4_n = 0; rstw_n = 0;
        b8.load_i = 0; b8.seed_i = '0; b8.ready_i = 0;
        b4.load_i = 0; b4.seed_i = '0; b4.ready_i = 0;
        bw.load_i = 0; bw.seed_i = '0; bw.ready_i = 0;
        #12;

        // Reset values
        chk("rst8_data", b8.data_o, 32'hFF);
        chk("rst8_valid", b8.valid_o, 1);
        chk("rst8_wrap", b8.wrap_o, 0);
        chk("rst8_period", b8.period_o, 0);
        chk("rst8_zseed", b8.zseed_o, 0);
        chk("rst4_data", b4.data_o, 32'hF);
        chk("rstw_valid", bw.valid_o, 0);
        chk("rstw_data", bw.data_o, 32'hFF);

        // Test 1: free run with ready_i=1 from reset
        b8.ready_i = 1;
        @(negedge clk) rst8_n = 1;
        for (int k = 0; k < 255; k++) begin
            if (k < 4) chk("t1_table", b8.data_o, exp1[k]);
            chk("t1_data", b8.data_o, nth(32'hFF, k, 8, 32'h1D));
            chk("t1_nowrap", b8.wrap_o, 0);
            tick();
        end
        chk("t1_wrap", b8.wrap_o, 1);
        chk("t1_period", b8.period_o, 255);
        chk("t1_back_to_seed", b8.data_o, 32'hFF);
        tick();
        chk("t1_wrap_pulse", b8.wrap_o, 0);
        chk("t1_after_wrap", b8.data_o, 32'hE3);
        b8.ready_i = 0;

        // Test 2: 4-bit non-maximal polynomial
        b4.ready_i = 1;
        @(negedge clk) rst4_n = 1;
        for (int k = 0; k < 8; k++) begin
            chk("t2_table", b4.data_o, exp4[k]);
            chk("t2_model", b4.data_o, nth(32'hF, k % 7, 4, 32'h7));
            chk("t2_wrap", b4.wrap_o, (k == 7) ? 32'd1 : 32'd0);
            if (k == 7) chk("t2_period", b4.period_o, 7);
            else tick();
        end
        b4.ready_i = 0;

        // Test 3: random back-pressure
        rst8_n = 0;
        @(negedge clk) rst8_n = 1;
        q = 32'hFF; n = 0; expw = 0;
        for (int c = 0; c < 600; c++) begin
            r = 1'($urandom_range(0, 1));
            b8.ready_i = r;
            chk("t3_data", b8.data_o, q);
            chk("t3_valid", b8.valid_o, 1);
            chk("t3_wrap", b8.wrap_o, expw);
            if (expw) chk("t3_period", b8.period_o, 255);
            tick();
            if (r) begin
                q = mulx(q, 8, 32'h1D);
                n++;
            end
            expw = r && (n % 255 == 0);
        end

        // Test 4: load with zero seed and same-cycle handshake
        b8.load_i = 1; b8.seed_i = '0; b8.ready_i = 1;
        tick();
        chk("t4_zero_data", b8.data_o, 32'hFF);
        chk("t4_zseed", b8.zseed_o, 1);
        chk("t4_valid", b8.valid_o, 1);
        b8.load_i = 0; b8.ready_i = 0;
        tick();
        chk("t4_zseed_pulse", b8.zseed_o, 0);
        chk("t4_no_advance", b8.data_o, 32'hFF);
        s = $urandom_range(1, 255);
        b8.load_i = 1; b8.seed_i = 8'(s); b8.ready_i = 1;
        tick();
        b8.load_i = 0;
        chk("t4_seed_data", b8.data_o, s);
        chk("t4_seed_zseed", b8.zseed_o, 0);
        q = s;
        for (int k = 0; k < 255; k++) begin
            chk("t4_run_data", b8.data_o, q);
            chk("t4_run_nowrap", b8.wrap_o, 0);
            tick();
            q = mulx(q, 8, 32'h1D);
        end
        chk("t4_wrap", b8.wrap_o, 1);
        chk("t4_period", b8.period_o, 255);
        chk("t4_back_to_seed", b8.data_o, s);

        // Test 5: warm-up of three advances
        bw.ready_i = 1;
        @(negedge clk) rstw_n = 1;
        for (int k = 0; k < 3; k++) begin
            chk("t5_warm_valid", bw.valid_o, 0);
            chk("t5_warm_data", bw.data_o, nth(32'hFF, k, 8, 32'h1D));
            tick();
        end
        chk("t5_valid", bw.valid_o, 1);
        chk("t5_first", bw.data_o, 32'hAB);
        q = 32'hAB;
        for (int k = 0; k < 255; k++) begin
            chk("t5_run_data", bw.data_o, q);
            chk("t5_nowrap", bw.wrap_o, 0);
            tick();
            q = mulx(q, 8, 32'h1D);
        end
        chk("t5_wrap", bw.wrap_o, 1);
        chk("t5_period", bw.period_o, 255);
        chk("t5_back_to_ref", bw.data_o, 32'hAB);

        // Back-to-back loads: the last wins and warm-up restarts
        bw.load_i = 1; bw.seed_i = 8'h5A;
        tick();
        bw.seed_i = 8'h3C;
        tick();
        bw.load_i = 0;
        chk("t5_b2b_data", bw.data_o, 32'h3C);
        chk("t5_b2b_valid", bw.valid_o, 0);
        tick(); tick();
        chk("t5_b2b_warm", bw.valid_o, 0);
        tick();
        chk("t5_b2b_valid_run", bw.valid_o, 1);
        chk("t5_b2b_run_data", bw.data_o, nth(32'h3C, 3, 8, 32'h1D));
        chk("t5_b2b_period_kept", bw.period_o, 255);

        // Test 6: asynchronous reset mid-WARM and mid-RUN
        bw.load_i = 1; bw.seed_i = 8'h11;
        tick();
        bw.load_i = 0;
        tick();
        #2 rstw_n = 0;
        #1;
        chk("t6_warm_rst_data", bw.data_o, 32'hFF);
        chk("t6_warm_rst_valid", bw.valid_o, 0);
        chk("t6_warm_rst_period", bw.period_o, 0);
        @(negedge clk) rstw_n = 1;
        chk("t6_warm_restart", bw.data_o, 32'hFF);
        tick();
        chk("t6_warm_restart2", bw.data_o, 32'hE3);

        b8.ready_i = 1;
        tick(); tick(); tick();
        #2 rst8_n = 0;
        #1;
        chk("t6_run_rst_data", b8.data_o, 32'hFF);
        chk("t6_run_rst_valid", b8.valid_o, 1);
        chk("t6_run_rst_period", b8.period_o, 0);
        chk("t6_run_rst_wrap", b8.wrap_o, 0);
        chk("t6_run_rst_zseed", b8.zseed_o, 0);
        @(negedge clk) rst8_n = 1;
        chk("t6_run_restart", b8.data_o, 32'hFF);
        tick();
        chk("t6_run_restart2", b8.data_o, 32'hE3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
